// File: rtl/data_sync.sv
// rtl/data_sync.sv - destination-domain bus synchronizer qualified by a level enable
//
// Purpose:
//    Brings a multi-bit bus from a foreign clock domain into the CLK domain.
//    The source holds UNSYNC_BUS stable while BUS_EN is high. Only BUS_EN
//    crosses through a flop chain. The rising edge of the synchronized enable
//    becomes a one-cycle strobe that captures the (by then settled) bus.
//
// Ports:
//    CLK           destination-domain clock
//    RST           asynchronous active-low reset (output of the domain's reset synchronizer)
//    UNSYNC_BUS    source-domain data, stable while BUS_EN is high
//    BUS_EN        source-domain level enable
//    SYNC_BUS      captured, synchronized data
//    ENABLE_PULSE  one-cycle strobe coincident with a new SYNC_BUS value
//    XFER_CNT      wrapping count of completed transfers
//    OVERRUN       sticky flag: enable re-asserted before the previous transfer settled
//    OVR_CLR       synchronous clear for OVERRUN (set has priority)

module data_sync #(
   parameter int BUS_WIDTH  = 8,
   parameter int NUM_STAGES = 2,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
   input  logic                 BUS_EN,
   output logic [BUS_WIDTH-1:0] SYNC_BUS,
   output logic                 ENABLE_PULSE,
   output logic [CNT_WIDTH-1:0] XFER_CNT,
   output logic                 OVERRUN,
   input  logic                 OVR_CLR
);

   // Guard counter must hold NUM_STAGES+1, at most 5 for the legal depth range.
   localparam int              GUARD_W    = 3;
   localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(NUM_STAGES + 1);

   generate
      if (NUM_STAGES < 2 || NUM_STAGES > 4) begin : g_bad_num_stages
         $error("data_sync: NUM_STAGES must be in 2..4");
      end
   endgenerate

   logic [NUM_STAGES-1:0] sync_chain;
   logic                  en_sync;
   logic                  en_prev;
   logic                  pulse_c;
   logic [GUARD_W-1:0]    guard_cnt;
   logic                  overrun_set;

   // Plain flop chain: no logic between stages so each stage has a full
   // cycle to resolve metastability.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sync_chain <= '0;
      end else begin
         sync_chain <= {sync_chain[NUM_STAGES-2:0], BUS_EN};
      end
   end

   assign en_sync = sync_chain[NUM_STAGES-1];

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         en_prev <= 1'b0;
      end else begin
         en_prev <= en_sync;
      end
   end

   // Rising edge of the synchronized enable: one pulse per enable level.
   assign pulse_c = en_sync & ~en_prev;

   // By the time en_sync rises, the bus has been stable for NUM_STAGES
   // cycles, so it is safe to sample it directly.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         SYNC_BUS     <= '0;
         ENABLE_PULSE <= 1'b0;
         XFER_CNT     <= '0;
      end else begin
         ENABLE_PULSE <= pulse_c;
         if (pulse_c) begin
            SYNC_BUS <= UNSYNC_BUS;
            XFER_CNT <= XFER_CNT + CNT_WIDTH'(1);
         end
      end
   end

   // Guard window after each capture: a new edge inside it means the source
   // toggled faster than the chain can safely follow.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         guard_cnt <= '0;
      end else if (pulse_c) begin
         guard_cnt <= GUARD_LOAD;
      end else if (guard_cnt != '0) begin
         guard_cnt <= guard_cnt - GUARD_W'(1);
      end
   end

   assign overrun_set = pulse_c & (guard_cnt != '0);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         OVERRUN <= 1'b0;
      end else if (overrun_set) begin
         OVERRUN <= 1'b1;
      end else if (OVR_CLR) begin
         OVERRUN <= 1'b0;
      end
   end

endmodule

// File: tb/tb_data_sync.sv
// tb/tb_data_sync.sv - self-checking bench for data_sync

module tb_data_sync;

   localparam int BW = 8;
   localparam int NS = 2;
   localparam int CW = 2;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic [BW-1:0] UNSYNC_BUS = '0;
   logic          BUS_EN = 1'b0;
   logic          OVR_CLR = 1'b0;
   logic [BW-1:0] SYNC_BUS;
   logic          ENABLE_PULSE;
   logic [CW-1:0] XFER_CNT;
   logic          OVERRUN;

   int total = 0;
   int bad   = 0;
   int pulses = 0;
   bit chk_on = 1'b0;

   data_sync #(.BUS_WIDTH(BW), .NUM_STAGES(NS), .CNT_WIDTH(CW)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .UNSYNC_BUS   (UNSYNC_BUS),
      .BUS_EN       (BUS_EN),
      .SYNC_BUS     (SYNC_BUS),
      .ENABLE_PULSE (ENABLE_PULSE),
      .XFER_CNT     (XFER_CNT),
      .OVERRUN      (OVERRUN),
      .OVR_CLR      (OVR_CLR)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: keeps the history of BUS_EN as seen at each clock edge.
   // A pulse is emitted when the sample taken NS edges ago is 1 and the one
   // before it is 0. Overrun: two pulses no more than NS+1 edges apart.
   logic [7:0]    hist_en;
   logic [BW-1:0] m_bus;
   logic          m_pulse;
   logic [CW-1:0] m_cnt;
   logic          m_ovr;
   int            edge_no;
   int            last_pulse_edge;
   bit            have_pulse;

   always @(posedge CLK or negedge RST) begin : model
      logic [7:0] h;
      logic       p;
      logic       near;
      if (!RST) begin
         hist_en         <= '0;
         m_bus           <= '0;
         m_pulse         <= 1'b0;
         m_cnt           <= '0;
         m_ovr           <= 1'b0;
         edge_no         <= 0;
         last_pulse_edge <= 0;
         have_pulse      <= 1'b0;
      end else begin
         h    = {hist_en[6:0], BUS_EN};
         p    = h[NS] & ~h[NS+1];
         near = have_pulse && ((edge_no + 1 - last_pulse_edge) <= NS + 1);
         hist_en <= h;
         edge_no <= edge_no + 1;
         m_pulse <= p;
         if (p) begin
            m_bus           <= UNSYNC_BUS;
            m_cnt           <= m_cnt + 1'b1;
            last_pulse_edge <= edge_no + 1;
            have_pulse      <= 1'b1;
         end
         if (p && near)  m_ovr <= 1'b1;
         else if (OVR_CLR) m_ovr <= 1'b0;
      end
   end

   always @(negedge CLK) begin
      if (chk_on) begin
         chk("cyc_pulse", 32'(ENABLE_PULSE), 32'(m_pulse));
         chk("cyc_bus",   32'(SYNC_BUS),     32'(m_bus));
         chk("cyc_cnt",   32'(XFER_CNT),     32'(m_cnt));
         chk("cyc_ovr",   32'(OVERRUN),      32'(m_ovr));
      end
      if (ENABLE_PULSE === 1'b1) pulses++;
   end

   // Inputs move 2 time units after each rising edge.
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #2;
      end
   endtask

   task automatic do_reset();
      RST = 1'b0;
      tick(2);
      RST = 1'b1;
      tick(1);
   endtask

   initial begin : stim
      int p0;
      logic en;
      int hold;
      int exp_wrap [5];
      exp_wrap = '{1, 2, 3, 0, 1};

      tick(3);
      chk_on = 1'b1;
      chk("rst_bus",   32'(SYNC_BUS),     32'h0);
      chk("rst_pulse", 32'(ENABLE_PULSE), 32'h0);
      chk("rst_cnt",   32'(XFER_CNT),     32'h0);
      chk("rst_ovr",   32'(OVERRUN),      32'h0);
      RST = 1'b1;
      tick(1);

      // Latency: enable set up before edge 0, pulse after edge 2.
      UNSYNC_BUS = 8'hA5;
      BUS_EN     = 1'b1;
      tick(1);
      tick(1);
      chk("lat_e1_pulse", 32'(ENABLE_PULSE), 32'h0);
      tick(1);
      chk("lat_e2_pulse", 32'(ENABLE_PULSE), 32'h1);
      chk("lat_e2_bus",   32'(SYNC_BUS),     32'hA5);
      chk("lat_e2_cnt",   32'(XFER_CNT),     32'h1);
      tick(1);
      chk("lat_e3_pulse", 32'(ENABLE_PULSE), 32'h0);

      // Hold enable high; bus change mid-hold must be ignored.
      p0 = pulses;
      for (int i = 0; i < 50; i++) begin
         if (i == 20) UNSYNC_BUS = 8'h3C;
         tick(1);
      end
      chk("hold_pulses", 32'(pulses - p0), 32'h0);
      chk("hold_bus",    32'(SYNC_BUS),    32'hA5);

      // Back-to-back transfers.
      BUS_EN = 1'b0;
      do_reset();
      p0 = pulses;
      for (int i = 1; i <= 3; i++) begin
         BUS_EN = 1'b0;
         tick(4);
         UNSYNC_BUS = 8'(i * 8'h11);
         BUS_EN = 1'b1;
         tick(4);
      end
      chk("b2b_pulses", 32'(pulses - p0), 32'h3);
      chk("b2b_bus",    32'(SYNC_BUS),    32'h33);
      chk("b2b_cnt",    32'(XFER_CNT),    32'h3);
      chk("b2b_ovr",    32'(OVERRUN),     32'h0);

      // Overrun: enable high 1 cycle, low 1 cycle, high again.
      BUS_EN = 1'b0;
      do_reset();
      tick(2);
      p0 = pulses;
      UNSYNC_BUS = 8'h55;
      BUS_EN = 1'b1;
      tick(1);
      BUS_EN = 1'b0;
      UNSYNC_BUS = 8'h66;
      tick(1);
      BUS_EN = 1'b1;
      tick(6);
      chk("ovr_pulses", 32'(pulses - p0), 32'h2);
      chk("ovr_set",    32'(OVERRUN),     32'h1);
      chk("ovr_bus",    32'(SYNC_BUS),    32'h66);
      tick(3);
      chk("ovr_sticky", 32'(OVERRUN),     32'h1);
      OVR_CLR = 1'b1;
      tick(1);
      OVR_CLR = 1'b0;
      chk("ovr_clr",    32'(OVERRUN),     32'h0);
      tick(1);
      chk("ovr_clr_hold", 32'(OVERRUN),   32'h0);

      // Counter wrap with a 2-bit counter.
      BUS_EN = 1'b0;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         BUS_EN = 1'b0;
         tick(4);
         UNSYNC_BUS = 8'h40 + 8'(i);
         BUS_EN = 1'b1;
         tick(4);
         chk($sformatf("wrap_%0d", i), 32'(XFER_CNT), 32'(exp_wrap[i]));
      end

      // Reset mid-operation.
      BUS_EN = 1'b0;
      tick(4);
      UNSYNC_BUS = 8'h77;
      BUS_EN = 1'b1;
      tick(1);
      #1;
      RST = 1'b0;
      #1;
      chk("mid_rst_bus",   32'(SYNC_BUS),     32'h0);
      chk("mid_rst_pulse", 32'(ENABLE_PULSE), 32'h0);
      chk("mid_rst_cnt",   32'(XFER_CNT),     32'h0);
      chk("mid_rst_ovr",   32'(OVERRUN),      32'h0);
      tick(2);
      p0 = pulses;
      RST = 1'b1;
      tick(1);
      chk("rel_e1_pulse", 32'(ENABLE_PULSE), 32'h0);
      tick(1);
      chk("rel_e2_pulse", 32'(ENABLE_PULSE), 32'h0);
      tick(1);
      chk("rel_e3_pulse", 32'(ENABLE_PULSE), 32'h1);
      chk("rel_e3_cnt",   32'(XFER_CNT),     32'h1);
      chk("rel_e3_bus",   32'(SYNC_BUS),     32'h77);
      tick(4);
      chk("rel_pulses",   32'(pulses - p0),  32'h1);

      // Randomized enable levels of random length, random clears.
      en = 1'b1;
      for (int k = 0; k < 1500; k++) begin
         en   = ~en;
         hold = $urandom_range(1, 8);
         if (en) UNSYNC_BUS = 8'($urandom);
         BUS_EN = en;
         for (int j = 0; j < hold; j++) begin
            if (!en) UNSYNC_BUS = 8'($urandom);
            OVR_CLR = ($urandom_range(0, 7) == 0);
            tick(1);
         end
      end
      OVR_CLR = 1'b0;
      BUS_EN  = 1'b0;
      tick(6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/data_sync.md
Name: data_sync

Overview:
Destination-domain bus synchronizer that transfers a multi-bit bus from another clock domain into the CLK domain, qualified by a single-bit level enable. It sits directly downstream of the reset synchronizer for its domain, and RST is that synchronizer's synchronized output. The enable is passed through a multi-flop synchronizer, and its rising edge is converted to a one-cycle pulse. That pulse captures the bus into an output register. A wrapping transfer counter and a sticky overrun flag are provided for debug and status.

Parameters:
BUS_WIDTH, 8, width of UNSYNC_BUS and SYNC_BUS
NUM_STAGES, 2, enable synchronizer depth; legal range 2..4; out-of-range values are a compile-time error
CNT_WIDTH, 8, width of XFER_CNT

Ports:
CLK  input  1  destination-domain clock
RST  input  1  asynchronous active-low reset, driven by the domain's reset synchronizer
UNSYNC_BUS  input  BUS_WIDTH  source-domain data; held stable by the source while BUS_EN is high
BUS_EN  input  1  source-domain level enable; high while UNSYNC_BUS is valid
SYNC_BUS  output  BUS_WIDTH  registered, synchronized data
ENABLE_PULSE  output  1  one-cycle strobe, coincident with new SYNC_BUS
XFER_CNT  output  CNT_WIDTH  number of completed transfers, wraps
OVERRUN  output  1  sticky: a new enable edge arrived too soon
OVR_CLR  input  1  synchronous clear for OVERRUN, CLK domain

Behaviour:
- Reset and clock: RST is asynchronous and active-low; clock is CLK. All flops are cleared on RST low.
- Reset values: sync chain = 0, en_prev = 0, SYNC_BUS = 0, ENABLE_PULSE = 0, XFER_CNT = 0, OVERRUN = 0, guard counter = 0.
- Enable synchronizer: NUM_STAGES flops in series, clocked by CLK. en_sync is the last stage. No logic is allowed between the stages.
- Pulse generation: en_prev <= en_sync. pulse_c = en_sync & ~en_prev.
- Output register: ENABLE_PULSE <= pulse_c. SYNC_BUS <= pulse_c ? UNSYNC_BUS : SYNC_BUS.
  - SYNC_BUS changes only in the cycle ENABLE_PULSE rises.
  - At all other times SYNC_BUS holds its last captured value.
- Latency: if BUS_EN goes high with setup met before CLK edge 0, ENABLE_PULSE is high for exactly the cycle following edge NUM_STAGES. For NUM_STAGES=2, that is after edge 2.
- Level-to-pulse: a BUS_EN held high for any duration produces exactly one pulse. A second pulse requires en_sync to be seen low for at least 1 cycle and then high again.
- XFER_CNT: increments by 1 on each pulse_c. Wraps from 2^CNT_WIDTH-1 to 0. No saturation.
- Guard counter and OVERRUN:
  - A guard counter loads NUM_STAGES+1 on pulse_c and decrements to 0.
  - If en_sync falls and rises again (pulse_c) while the guard counter is nonzero, OVERRUN <= 1. The capture and pulse still occur.
  - OVR_CLR=1 clears OVERRUN on the next edge. If OVR_CLR and a new overrun event occur in the same cycle, set wins.
- Mid-operation reset: all state clears asynchronously. After RST releases with BUS_EN already high, the chain refills, and one pulse occurs NUM_STAGES+1 edges after release. This pulse is a legitimate transfer.
- BUS_EN low for less than 1 CLK period: the edge may be missed. No pulse and no error are required, and the block must not produce a double pulse.
- UNSYNC_BUS changing while BUS_EN is low does not affect SYNC_BUS.

Test Plan:
- Reset and latency: with NUM_STAGES=2, release RST. Drive UNSYNC_BUS=0xA5 and BUS_EN=1 before edge 0. Required: ENABLE_PULSE=1 only in the cycle after edge 2, SYNC_BUS=0xA5 from that cycle onward, XFER_CNT=1.
- Hold: keep BUS_EN=1 for 50 cycles and change UNSYNC_BUS to 0x3C at cycle 20. Required: exactly one pulse, and SYNC_BUS stays 0xA5.
- Back-to-back: run 3 transfers (0x11, 0x22, 0x33), each with BUS_EN low 4 cycles then high 4 cycles. Required: 3 pulses, SYNC_BUS ends at 0x33, XFER_CNT=3, OVERRUN=0.
- Overrun and clear: after a pulse, drop BUS_EN for 1 cycle, then raise it. Required: second pulse occurs and OVERRUN=1 sticky. Pulse OVR_CLR for 1 cycle, and OVERRUN=0 on the next edge.
- Wrap: with CNT_WIDTH=2, run 5 transfers. Required: XFER_CNT sequence 1, 2, 3, 0, 1.
- Reset mid-operation: assert RST one cycle after BUS_EN rises. Required: all outputs are 0 immediately. Release RST with BUS_EN still high: exactly one pulse NUM_STAGES+1 edges later, and XFER_CNT=1.
